// File: rtl/serial_byte_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_byte_deserializer
// Purpose  : Assembles strobe-qualified serial frames (start bit, 8 data bits
//            LSB first, optional even-parity bit, stop bit) into bytes. Each
//            good byte is presented with a one-cycle data_valid pulse. Bad
//            frames are dropped, flagged with one-cycle error pulses and
//            counted in a saturating counter.
// Build    : define SERIAL_PARITY_EN to add the parity bit and parity check.
//            Without it, frames are 10 bits and parity_err is tied to 0.
// Ports    : clk         rising-edge clock
//            reset       synchronous, active-high reset
//            bit_in      serial data, qualified by bit_valid
//            bit_valid   one-cycle strobe marking a sampled bit
//            data_out    last good byte (held between frames)
//            data_valid  one-cycle pulse when data_out updates
//            frame_err   one-cycle pulse: stop bit sampled as 0
//            parity_err  one-cycle pulse: parity mismatch
//            busy        high while a frame is in progress
//            err_count   saturating count of bad frames
// Revision : 1.0 - initial release
// ============================================================================
module serial_byte_deserializer #(
  parameter int DATA_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] C_LAST_BIT = 3'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   par_mis;

`ifdef SERIAL_PARITY_EN
  logic                   par_q, par_d;
  logic                   parity_err_q, parity_err_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_mis = ^{shreg_q, par_q};
`else
  assign par_mis = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
`ifdef SERIAL_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // A 1 on the line while idle is just the idle level; only a 0 starts a frame.
        if (bit_valid && !bit_in) begin
          state_d = DATA;
          cnt_d   = 3'd0;
        end
      end

      DATA: begin
        if (bit_valid) begin
          // Right shift with new bit entering at the MSB: after 8 bits the
          // first (LSB) bit has reached bit 0.
          shreg_d = {bit_in, shreg_q[DATA_W-1:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == C_LAST_BIT) begin
`ifdef SERIAL_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef SERIAL_PARITY_EN
      PARITY: begin
        if (bit_valid) begin
          par_d   = bit_in;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_valid) begin
          // A 0 stop bit is not reused as a start bit; always return to IDLE.
          state_d = IDLE;
          if (bit_in && !par_mis) begin
            data_out_d   = shreg_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d = !bit_in;
`ifdef SERIAL_PARITY_EN
            parity_err_d = par_mis;
`endif
            // One increment per bad frame regardless of how many error types.
            if (err_count_q != {ERR_CNT_W{1'b1}}) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= 3'd0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_count_q  <= '0;
`ifdef SERIAL_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      err_count_q  <= err_count_d;
`ifdef SERIAL_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign err_count  = err_count_q;
`ifdef SERIAL_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_byte_deserializer
// Purpose  : Self-checking bench for serial_byte_deserializer. Frames are
//            described as (byte, parity bit, stop bit); a frame-level model
//            predicts the result pulses, the held byte and the error count.
//            Works with or without SERIAL_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_byte_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;
  logic [7:0] err_count;

`ifdef SERIAL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int ERR_MAX = 255;

  serial_byte_deserializer #(.DATA_W(8), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Frame-level reference model
  logic [7:0] m_data;
  int         m_err;
  logic       exp_dv, exp_fe, exp_pe;

  task automatic model_reset();
    m_data = 8'h00;
    m_err  = 0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic p, input logic s);
    exp_fe = !s;
    exp_pe = PAR && (((^b) ^ p) != 1'b0);
    exp_dv = !exp_fe && !exp_pe;
    if (exp_dv) m_data = b;
    else if (m_err < ERR_MAX) m_err = m_err + 1;
  endtask

  // One strobed bit: inputs change 1 time unit after a rising edge, outputs
  // are read 1 time unit after the edge that samples the strobe.
  task automatic strobe(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0; bit_in = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends a complete frame. Returns with the stop-bit edge just passed.
  // stray counts result pulses seen before the stop edge; busy_low counts
  // in-frame cycles (after start) where busy was low.
  task automatic drive_frame(input logic [7:0] b, input logic p, input logic s,
                             input int maxgap, input bit rst_at_stop,
                             output int stray, output int busy_low);
    logic bits [11];
    int   n, gap;
    n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[n++] = b[i];
    if (PAR) bits[n++] = p;
    bits[n++] = s;
    stray = 0; busy_low = 0;
    for (int i = 0; i < n; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        @(posedge clk); #1;
        if (data_valid || frame_err || parity_err) stray++;
        if (i > 0 && !busy) busy_low++;
      end
      if (i == n - 1 && rst_at_stop) reset = 1'b1;
      strobe(bits[i]);
      reset = 1'b0;
      if (i < n - 1) begin
        if (data_valid || frame_err || parity_err) stray++;
        if (!busy) busy_low++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b1;
    idle_cycles(3);
    reset = 1'b0;
    model_reset();
    idle_cycles(1);
    checks++;
    if ({data_valid, frame_err, parity_err, busy, data_out, err_count} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got dv=%b fe=%b pe=%b busy=%b data=%h cnt=%0d, want all 0",
               data_valid, frame_err, parity_err, busy, data_out, err_count);
    end
  endtask

  task automatic test_good_frame();
    int stray, bl;
    model_frame(8'hA5, ^8'hA5, 1'b1);
    drive_frame(8'hA5, ^8'hA5, 1'b1, 0, 1'b0, stray, bl);
    checks++;
    if ({data_valid, frame_err, parity_err, data_out, err_count} !== {exp_dv, exp_fe, exp_pe, m_data, 8'(m_err)}) begin
      errors++;
      $display("FAIL good_frame: got dv=%b fe=%b pe=%b data=%h cnt=%0d, want dv=%b fe=%b pe=%b data=%h cnt=%0d",
               data_valid, frame_err, parity_err, data_out, err_count, exp_dv, exp_fe, exp_pe, m_data, m_err);
    end
    checks++;
    if (stray != 0 || bl != 0) begin
      errors++;
      $display("FAIL good_frame_inframe: got stray=%0d busy_low=%0d, want 0 0", stray, bl);
    end
    idle_cycles(1);
    checks++;
    if ({data_valid, frame_err, parity_err, busy} !== 4'b0 || data_out !== 8'hA5) begin
      errors++;
      $display("FAIL good_frame_after: got dv=%b fe=%b pe=%b busy=%b data=%h, want 0 0 0 0 a5",
               data_valid, frame_err, parity_err, busy, data_out);
    end
  endtask

  task automatic test_gapped();
    int stray, bl;
    for (int k = 0; k < 3; k++) begin
      model_frame(8'hA5, ^8'hA5, 1'b1);
      drive_frame(8'hA5, ^8'hA5, 1'b1, 7, 1'b0, stray, bl);
      checks++;
      if ({data_valid, frame_err, parity_err, data_out, err_count} !== {exp_dv, exp_fe, exp_pe, m_data, 8'(m_err)} ||
          stray != 0 || bl != 0) begin
        errors++;
        $display("FAIL gapped: got dv=%b fe=%b pe=%b data=%h cnt=%0d stray=%0d busy_low=%0d, want dv=1 fe=0 pe=0 data=%h cnt=%0d stray=0 busy_low=0",
                 data_valid, frame_err, parity_err, data_out, err_count, stray, bl, m_data, m_err);
      end
      idle_cycles(1);
    end
  endtask

  task automatic test_frame_err();
    int stray, bl;
    model_frame(8'h3C, ^8'h3C, 1'b0);
    drive_frame(8'h3C, ^8'h3C, 1'b0, 2, 1'b0, stray, bl);
    checks++;
    if ({data_valid, frame_err, parity_err, data_out, err_count} !== {exp_dv, exp_fe, exp_pe, m_data, 8'(m_err)} || stray != 0) begin
      errors++;
      $display("FAIL frame_err: got dv=%b fe=%b pe=%b data=%h cnt=%0d stray=%0d, want dv=%b fe=%b pe=%b data=%h cnt=%0d stray=0",
               data_valid, frame_err, parity_err, data_out, err_count, stray, exp_dv, exp_fe, exp_pe, m_data, m_err);
    end
    idle_cycles(1);
    checks++;
    if ({data_valid, frame_err, parity_err, busy} !== 4'b0) begin
      errors++;
      $display("FAIL frame_err_width: got dv=%b fe=%b pe=%b busy=%b, want 0 0 0 0", data_valid, frame_err, parity_err, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int stray, bl;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom_range(0, 1)));
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    model_reset();
    checks++;
    if ({busy, data_valid, frame_err, parity_err, data_out, err_count} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_frame: got busy=%b dv=%b fe=%b pe=%b data=%h cnt=%0d, want all 0",
               busy, data_valid, frame_err, parity_err, data_out, err_count);
    end
    model_frame(8'h81, ^8'h81, 1'b1);
    drive_frame(8'h81, ^8'h81, 1'b1, 1, 1'b0, stray, bl);
    checks++;
    if ({data_valid, frame_err, parity_err, data_out, err_count} !== {1'b1, 1'b0, 1'b0, 8'h81, 8'h00} || stray != 0) begin
      errors++;
      $display("FAIL reset_then_81: got dv=%b fe=%b pe=%b data=%h cnt=%0d stray=%0d, want dv=1 fe=0 pe=0 data=81 cnt=0 stray=0",
               data_valid, frame_err, parity_err, data_out, err_count, stray);
    end
    idle_cycles(1);
  endtask

  // Reset coinciding with the stop strobe must suppress every result.
  task automatic test_reset_at_stop();
    int stray, bl;
    for (int k = 0; k < 2; k++) begin
      drive_frame(8'h5A, ^8'h5A, 1'(k), 0, 1'b1, stray, bl);
      model_reset();
      checks++;
      if ({data_valid, frame_err, parity_err, busy, data_out, err_count} !== 20'h0) begin
        errors++;
        $display("FAIL reset_at_stop%0d: got dv=%b fe=%b pe=%b busy=%b data=%h cnt=%0d, want all 0",
                 k, data_valid, frame_err, parity_err, busy, data_out, err_count);
      end
      idle_cycles(1);
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    int stray, bl;
    logic [1:0] cases [3];
    cases[0] = 2'b11;  // parity 1, stop 1: good
    cases[1] = 2'b01;  // parity 0, stop 1: parity error only
    cases[2] = 2'b00;  // parity 0, stop 0: both errors, one count
    for (int k = 0; k < 3; k++) begin
      model_frame(8'h07, cases[k][1], cases[k][0]);
      drive_frame(8'h07, cases[k][1], cases[k][0], 1, 1'b0, stray, bl);
      checks++;
      if ({data_valid, frame_err, parity_err, data_out, err_count} !== {exp_dv, exp_fe, exp_pe, m_data, 8'(m_err)} || stray != 0) begin
        errors++;
        $display("FAIL parity%0d: got dv=%b fe=%b pe=%b data=%h cnt=%0d stray=%0d, want dv=%b fe=%b pe=%b data=%h cnt=%0d stray=0",
                 k, data_valid, frame_err, parity_err, data_out, err_count, stray, exp_dv, exp_fe, exp_pe, m_data, m_err);
      end
      idle_cycles(1);
    end
  endtask
`endif

  task automatic test_random();
    int stray, bl;
    logic [7:0] b;
    logic p, s;
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      p = (^b) ^ ($urandom_range(0, 4) == 0);
      s = ($urandom_range(0, 4) != 0);
      // Idle-level strobes before the start bit must be ignored.
      repeat ($urandom_range(0, 2)) strobe(1'b1);
      model_frame(b, p, s);
      drive_frame(b, p, s, $urandom_range(0, 3), 1'b0, stray, bl);
      checks++;
      if ({data_valid, frame_err, parity_err, data_out, err_count} !== {exp_dv, exp_fe, exp_pe, m_data, 8'(m_err)} ||
          stray != 0 || bl != 0) begin
        errors++;
        $display("FAIL random%0d: got dv=%b fe=%b pe=%b data=%h cnt=%0d stray=%0d busy_low=%0d, want dv=%b fe=%b pe=%b data=%h cnt=%0d 0 0",
                 k, data_valid, frame_err, parity_err, data_out, err_count, stray, bl, exp_dv, exp_fe, exp_pe, m_data, m_err);
      end
    end
    idle_cycles(1);
    checks++;
    if ({data_valid, frame_err, parity_err, busy} !== 4'b0) begin
      errors++;
      $display("FAIL random_tail: got dv=%b fe=%b pe=%b busy=%b, want 0 0 0 0", data_valid, frame_err, parity_err, busy);
    end
  endtask

  task automatic test_saturation();
    int stray, bl;
    logic [7:0] keep;
    keep = m_data;
    for (int k = 0; k < 260; k++) begin
      model_frame(8'($urandom), 1'b0, 1'b0);
      drive_frame(8'($urandom), 1'b0, 1'b0, 0, 1'b0, stray, bl);
    end
    checks++;
    if (err_count !== 8'd255 || m_err != ERR_MAX || data_out !== keep) begin
      errors++;
      $display("FAIL saturation: got cnt=%0d data=%h, want cnt=255 data=%h", err_count, data_out, keep);
    end
    model_frame(8'h11, 1'b0, 1'b0);
    drive_frame(8'h11, 1'b0, 1'b0, 0, 1'b0, stray, bl);
    checks++;
    if (err_count !== 8'd255 || frame_err !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL saturation_hold: got cnt=%0d fe=%b dv=%b, want cnt=255 fe=1 dv=0", err_count, frame_err, data_valid);
    end
    idle_cycles(2);
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b1; bit_valid = 1'b0;
    model_reset();
    exp_dv = 1'b0; exp_fe = 1'b0; exp_pe = 1'b0;
    #1;
    test_reset();
    test_good_frame();
    test_gapped();
    test_frame_err();
    test_reset_mid_frame();
    test_reset_at_stop();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
